// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave interface.
package spi_slave_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int SYNC_STAGES    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/spi_slave_sync.sv
// Multi-stage synchronizer with registered level, rise and fall outputs.
// Level and edge pulses become visible together, 3 clk after the pin changes.
module spi_slave_sync
  import spi_slave_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_r;
  logic                   level_r;
  logic                   rise_r;
  logic                   fall_r;

  // synchronizer chain followed by a registered edge detector
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      chain_r <= {SYNC_STAGES{RST_VAL}};
      level_r <= RST_VAL;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      chain_r <= {chain_r[SYNC_STAGES-2:0], din};
      level_r <= chain_r[SYNC_STAGES-1];
      rise_r  <= chain_r[SYNC_STAGES-1] & ~level_r;
      fall_r  <= ~chain_r[SYNC_STAGES-1] & level_r;
    end
  end

  assign level = level_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave with TX storage. Define SPI_SLAVE_TX_FIFO_EN for a
// TX_DEPTH-word TX FIFO; otherwise a single holding register is used.
module spi_slave_if
  import spi_slave_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TX_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  n_cs,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_din,
  input  logic                  tx_wrreq,
  output logic                  tx_full,
  output logic [DATA_WIDTH-1:0] rx_dout,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  tx_underrun
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
  logic cs_lvl_s, cs_rise_s, cs_fall_s;
  logic mosi_lvl_s, mosi_rise_s, mosi_fall_s;

  state_t state_r, next_state_s;
  logic   start_s, shift_in_s, shift_out_s, last_s, abort_s, close_s;

  logic [DATA_WIDTH-1:0] tx_shift_r, rx_shift_r, rx_dout_r;
  logic [CNT_W-1:0]      bit_cnt_r;
  logic                  miso_r, miso_oe_r, busy_r;
  logic                  rx_valid_r, frame_err_r, tx_underrun_r;

  logic                  tx_empty_s, push_s, pop_s;
  logic [DATA_WIDTH-1:0] head_word_s, head_s;

  spi_slave_sync #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .n_rst(n_rst), .din(sclk),
    .level(sclk_lvl_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  spi_slave_sync #(.RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .n_rst(n_rst), .din(n_cs),
    .level(cs_lvl_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  spi_slave_sync #(.RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .n_rst(n_rst), .din(mosi),
    .level(mosi_lvl_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
  );

  // only the mosi level and the sclk edges take part in the protocol
  logic unused_s;
  assign unused_s = ^{sclk_lvl_s, mosi_rise_s, mosi_fall_s, rx_shift_r[DATA_WIDTH-1]};

  // state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // next state and per-clk datapath strobes; n_cs rise wins over sclk edges
  always_comb begin
    next_state_s = state_r;
    start_s      = 1'b0;
    shift_in_s   = 1'b0;
    shift_out_s  = 1'b0;
    last_s       = 1'b0;
    abort_s      = 1'b0;
    close_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (cs_fall_s) begin
          next_state_s = SHIFT;
          start_s      = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cs_rise_s) begin
          next_state_s = IDLE;
          abort_s      = 1'b1;
        end else if (sclk_rise_s) begin
          shift_in_s = 1'b1;
          if (bit_cnt_r == LAST_CNT) begin
            next_state_s = DONE;
            last_s       = 1'b1;
          end else begin
            next_state_s = SHIFT;
          end
        end else if (sclk_fall_s) begin
          shift_out_s = 1'b1;
        end else begin
          next_state_s = SHIFT;
        end
      end
      DONE: begin
        if (cs_rise_s) begin
          next_state_s = IDLE;
          close_s      = 1'b1;
        end else if (sclk_fall_s) begin
          next_state_s = SHIFT;
          start_s      = 1'b1;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // an empty store sends an all-zero word
  always_comb begin
    if (tx_empty_s) begin
      head_s = {DATA_WIDTH{1'b0}};
    end else begin
      head_s = head_word_s;
    end
  end

  // shift registers, counter and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_shift_r    <= {DATA_WIDTH{1'b0}};
      rx_shift_r    <= {DATA_WIDTH{1'b0}};
      rx_dout_r     <= {DATA_WIDTH{1'b0}};
      bit_cnt_r     <= {CNT_W{1'b0}};
      miso_r        <= 1'b0;
      miso_oe_r     <= 1'b0;
      busy_r        <= 1'b0;
      rx_valid_r    <= 1'b0;
      frame_err_r   <= 1'b0;
      tx_underrun_r <= 1'b0;
    end else begin
      miso_oe_r     <= ~cs_lvl_s;
      rx_valid_r    <= last_s;
      frame_err_r   <= abort_s;
      tx_underrun_r <= start_s & tx_empty_s;

      if (start_s) begin
        busy_r <= 1'b1;
      end else if (abort_s || close_s) begin
        busy_r <= 1'b0;
      end

      if (start_s) begin
        tx_shift_r <= head_s;
        miso_r     <= head_s[DATA_WIDTH-1];
        bit_cnt_r  <= {CNT_W{1'b0}};
      end else if (shift_out_s) begin
        tx_shift_r <= tx_shift_r << 1;
        miso_r     <= tx_shift_r[DATA_WIDTH-2];
      end else if (abort_s || close_s) begin
        miso_r <= 1'b0;
      end

      if (shift_in_s) begin
        rx_shift_r <= {rx_shift_r[DATA_WIDTH-2:0], mosi_lvl_s};
        bit_cnt_r  <= bit_cnt_r + CNT_W'(1);
      end

      if (last_s) begin
        rx_dout_r <= {rx_shift_r[DATA_WIDTH-2:0], mosi_lvl_s};
      end
    end
  end

`ifdef SPI_SLAVE_TX_FIFO_EN
  localparam int PTR_W = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int OCC_W = $clog2(TX_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_r [TX_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
  logic [OCC_W-1:0]      occ_r, occ_next_s;
  logic                  tx_full_r;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(TX_DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign push_s      = tx_wrreq & ~tx_full_r;
  assign pop_s       = start_s & ~tx_empty_s;
  assign tx_empty_s  = (occ_r == {OCC_W{1'b0}});
  assign head_word_s = mem_r[rd_ptr_r];
  assign tx_full     = tx_full_r;

  // net occupancy after this clk's push and pop
  always_comb begin
    occ_next_s = occ_r;
    if (push_s && !pop_s) begin
      occ_next_s = occ_r + OCC_W'(1);
    end else if (pop_s && !push_s) begin
      occ_next_s = occ_r - OCC_W'(1);
    end else begin
      occ_next_s = occ_r;
    end
  end

  // FIFO pointers, occupancy and full flag
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      occ_r     <= {OCC_W{1'b0}};
      tx_full_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      occ_r     <= occ_next_s;
      tx_full_r <= (occ_next_s == OCC_W'(TX_DEPTH));
    end
  end

  // FIFO storage array
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= tx_din;
    end
  end
`else
  logic [DATA_WIDTH-1:0] hold_r;
  logic                  hold_valid_r;
  logic [31:0]           unused_depth_s;

  assign unused_depth_s = TX_DEPTH;
  assign push_s         = tx_wrreq & ~hold_valid_r;
  assign pop_s          = start_s & hold_valid_r;
  assign tx_empty_s     = ~hold_valid_r;
  assign head_word_s    = hold_r;
  assign tx_full        = hold_valid_r;

  // single-word holding register; push and pop never coincide
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold_r       <= {DATA_WIDTH{1'b0}};
      hold_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        hold_r       <= tx_din;
        hold_valid_r <= 1'b1;
      end else if (pop_s) begin
        hold_valid_r <= 1'b0;
      end
    end
  end
`endif

  assign miso        = miso_r;
  assign miso_oe     = miso_oe_r;
  assign rx_dout     = rx_dout_r;
  assign rx_valid    = rx_valid_r;
  assign busy        = busy_r;
  assign frame_err   = frame_err_r;
  assign tx_underrun = tx_underrun_r;

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: directed table, FIFO/back-to-back/reset
// sequences and randomized frames against a queue-based TX model.
module tb_spi_slave_if;

  localparam int HALF = 6;
`ifdef SPI_SLAVE_TX_FIFO_EN
  localparam int MDEPTH = 4;
`else
  localparam int MDEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        n_rst, sclk, mosi, n_cs, tx_wrreq;
  logic [15:0] tx_din;
  logic        miso, miso_oe, tx_full, rx_valid, busy, frame_err, tx_underrun;
  logic [15:0] rx_dout;

  int checks = 0;
  int failures = 0;
  int n_valid = 0, n_ur = 0, n_err = 0, n_miso_bad = 0;

  logic [15:0] txq[$];
  logic [15:0] last_rx;

  spi_slave_if #(.DATA_WIDTH(16), .TX_DEPTH(4)) dut (
    .clk(clk), .n_rst(n_rst), .sclk(sclk), .mosi(mosi), .n_cs(n_cs),
    .miso(miso), .miso_oe(miso_oe), .tx_din(tx_din), .tx_wrreq(tx_wrreq),
    .tx_full(tx_full), .rx_dout(rx_dout), .rx_valid(rx_valid), .busy(busy),
    .frame_err(frame_err), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) n_valid++;
    if (tx_underrun) n_ur++;
    if (frame_err) n_err++;
    if (!miso_oe && miso) n_miso_bad++;
  end

  typedef struct {
    bit          wr;
    logic [15:0] tx;
    logic [15:0] mw;
    int          nbits;
    logic [15:0] exp_rd;
    logic [15:0] exp_rx;
    int          exp_val;
    int          exp_ur;
    int          exp_err;
  } vec_t;

  vec_t vecs[3];

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tx_write(input logic [15:0] w);
    tx_din   = w;
    tx_wrreq = 1'b1;
    wait_clk(1);
    tx_wrreq = 1'b0;
  endtask

  // mode-0 master: data changes on fall, sampled on rise
  task automatic master_frame(input logic [15:0] mw, input int nbits, input bit hold_cs,
                              output logic [15:0] rd);
    rd   = 16'h0000;
    n_cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mw[15-i];
      wait_clk(HALF);
      sclk = 1'b1;
      rd   = {rd[14:0], miso};
      wait_clk(HALF);
      sclk = 1'b0;
      if (i == nbits - 1 && !hold_cs) n_cs = 1'b1;
    end
  endtask

  task automatic do_frame(input string nm, input logic [15:0] mw, input int nbits,
                          input logic [15:0] exp_rd, input logic [15:0] exp_rx,
                          input int ev, input int eu, input int ee);
    int v0, u0, e0;
    logic [15:0] rd;
    v0 = n_valid; u0 = n_ur; e0 = n_err;
    master_frame(mw, nbits, 1'b0, rd);
    wait_clk(4);
    check({nm, "_busy"}, busy, 0);
    wait_clk(8);
    check({nm, "_rd"}, rd, exp_rd);
    check({nm, "_rx"}, rx_dout, exp_rx);
    check({nm, "_valid"}, n_valid - v0, ev);
    check({nm, "_underrun"}, n_ur - u0, eu);
    check({nm, "_err"}, n_err - e0, ee);
  endtask

  initial begin
    logic [15:0] rd1, rd2, d, mw, word;
    int v0, nb, nw;
    bit ur;

    vecs[0] = '{1'b1, 16'hA55A, 16'h1234, 16, 16'hA55A, 16'h1234, 1, 0, 0};
    vecs[1] = '{1'b0, 16'h0000, 16'hFFFF, 16, 16'h0000, 16'hFFFF, 1, 1, 0};
    vecs[2] = '{1'b1, 16'h8001, 16'hABCD, 7,  16'h0040, 16'hFFFF, 0, 0, 1};

    n_rst = 1'b0; sclk = 1'b0; mosi = 1'b0; n_cs = 1'b1;
    tx_wrreq = 1'b0; tx_din = 16'h0000;
    wait_clk(3);
    check("reset_outputs",
          {miso, miso_oe, rx_dout, rx_valid, busy, frame_err, tx_underrun, tx_full}, 0);
    n_rst = 1'b1;
    wait_clk(5);
    last_rx = 16'h0000;

    for (int i = 0; i < 3; i++) begin
      if (vecs[i].wr) tx_write(vecs[i].tx);
      do_frame($sformatf("vec%0d", i), vecs[i].mw, vecs[i].nbits, vecs[i].exp_rd,
               vecs[i].exp_rx, vecs[i].exp_val, vecs[i].exp_ur, vecs[i].exp_err);
      last_rx = vecs[i].exp_rx;
    end

    // fill the store past capacity, then drain it
    for (int i = 0; i <= MDEPTH; i++) begin
      tx_write(16'(i + 1));
      check($sformatf("fill_full%0d", i), tx_full, (i + 1 >= MDEPTH) ? 1 : 0);
    end
    for (int k = 0; k <= MDEPTH; k++) begin
      do_frame($sformatf("drain%0d", k), 16'(16'h1000 + k), 16,
               (k < MDEPTH) ? 16'(k + 1) : 16'h0000, 16'(16'h1000 + k),
               1, (k == MDEPTH) ? 1 : 0, 0);
      last_rx = 16'(16'h1000 + k);
    end

    // back-to-back frames with n_cs held low
    tx_write(16'hBEEF);
    v0 = n_valid;
    fork
      begin
        master_frame(16'h1111, 16, 1'b1, rd1);
        master_frame(16'h2222, 16, 1'b0, rd2);
      end
      begin
        wait_clk(30);
        tx_write(16'hCAFE);
      end
    join
    wait_clk(4);
    check("b2b_busy", busy, 0);
    wait_clk(8);
    check("b2b_rd1", rd1, 16'hBEEF);
    check("b2b_rd2", rd2, 16'hCAFE);
    check("b2b_rx", rx_dout, 16'h2222);
    check("b2b_valid", n_valid - v0, 2);
    last_rx = 16'h2222;

    // reset in the middle of a frame, with a word left in storage
    tx_write(16'h5A5A);
    master_frame(16'h0F0F, 5, 1'b1, rd1);
    tx_write(16'h7777);
    n_rst = 1'b0; n_cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    wait_clk(2);
    check("midrst_outputs",
          {miso, miso_oe, rx_dout, rx_valid, busy, frame_err, tx_underrun, tx_full}, 0);
    n_rst = 1'b1;
    wait_clk(6);
    txq.delete();
    tx_write(16'h1357);
    do_frame("after_rst", 16'h2468, 16, 16'h1357, 16'h2468, 1, 0, 0);
    last_rx = 16'h2468;

    // randomized writes and frames against the queue model
    for (int it = 0; it < 10; it++) begin
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) begin
        d = 16'($urandom);
        tx_write(d);
        if (txq.size() < MDEPTH) txq.push_back(d);
        check($sformatf("rnd%0d_full", it), tx_full, (txq.size() == MDEPTH) ? 1 : 0);
      end
      mw = 16'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 16;
      ur = (txq.size() == 0);
      word = ur ? 16'h0000 : txq.pop_front();
      do_frame($sformatf("rnd%0d", it), mw, nb, word >> (16 - nb),
               (nb == 16) ? mw : last_rx, (nb == 16) ? 1 : 0, ur ? 1 : 0,
               (nb == 16) ? 0 : 1);
      if (nb == 16) last_rx = mw;
    end

    check("miso_quiet_when_disabled", n_miso_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
